// File: rtl/scr_pkg.sv
// Shared constants and types for the scratch RAM stack controller.
package scr_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 10;

   typedef enum logic [2:0] {
      OP_ST   = 3'd0,
      OP_LD   = 3'd1,
      OP_PUSH = 3'd2,
      OP_POP  = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5,
      OP_WSP  = 3'd6,
      OP_RSP  = 3'd7
   } scr_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/scr_stack_ctrl_if.sv
// Operation request / response handshake between the control unit and the stack controller.
interface scr_stack_ctrl_if;
   import scr_pkg::*;

   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output op_valid, op_code, op_addr, op_data,
      input  op_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  op_valid, op_code, op_addr, op_data,
      output op_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/stack_pointer.sv
// Stack pointer and depth counter; the caller guards dec/inc against full/empty.
module stack_pointer
   import scr_pkg::*;
#(
   parameter int unsigned MAX_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] sp_minus1,
   output logic              full,
   output logic              empty
);

   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

   logic [DEPTH_W-1:0] depth;

   assign sp_minus1 = sp - ADDR_W'(1);
   assign full      = (depth == DEPTH_W'(MAX_DEPTH));
   assign empty     = (depth == '0);

   // SP moves down on push (dec), up on pop (inc); load resets depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp    <= '0;
         depth <= '0;
      end else if (load) begin
         sp    <= load_val;
         depth <= '0;
      end else if (dec) begin
         sp    <= sp_minus1;
         depth <= depth + DEPTH_W'(1);
      end else if (inc) begin
         sp    <= sp + ADDR_W'(1);
         depth <= depth - DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/scr_stack_ctrl.sv
// Sequencing front-end for the 256 x 10-bit scratch RAM: direct access, stack ops, SP access.
module scr_stack_ctrl
   import scr_pkg::*;
#(
   parameter int unsigned MAX_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   scr_stack_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] sp_out,
   output logic [ADDR_W-1:0] scr_addr,
   output logic              scr_wr,
   output logic [DATA_W-1:0] scr_din,
   input  logic [DATA_W-1:0] scr_dout
);

   state_t            state;
   scr_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic              wr_q;
   logic              ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   logic [ADDR_W-1:0] sp;
   logic [ADDR_W-1:0] sp_minus1;
   logic [ADDR_W-1:0] sp_next;
   logic              full;
   logic              empty;
   logic              sp_inc;
   logic              sp_dec;
   logic              sp_load;
   scr_op_t           op_in;
   logic              push_in;
   logic              pop_in;
   logic              err_in;
   logic              push_q;
   logic              pop_q;

   stack_pointer #(.MAX_DEPTH(MAX_DEPTH)) u_sp (
      .clk       (clk),
      .rst       (rst),
      .inc       (sp_inc),
      .dec       (sp_dec),
      .load      (sp_load),
      .load_val  (addr_q),
      .sp        (sp),
      .sp_minus1 (sp_minus1),
      .full      (full),
      .empty     (empty)
   );

   assign op_in   = scr_op_t'(bus.op_code);
   assign push_in = (op_in == OP_PUSH) || (op_in == OP_CALL);
   assign pop_in  = (op_in == OP_POP)  || (op_in == OP_RET);
   assign err_in  = (push_in && full) || (pop_in && empty);
   assign push_q  = (op_q == OP_PUSH) || (op_q == OP_CALL);
   assign pop_q   = (op_q == OP_POP)  || (op_q == OP_RET);

   // SP/depth updates happen on the EXEC edge, suppressed for erroring ops.
   assign sp_dec  = (state == EXEC) && push_q && !err_q;
   assign sp_inc  = (state == EXEC) && pop_q  && !err_q;
   assign sp_load = (state == EXEC) && (op_q == OP_WSP);

   // SP value after the EXEC edge, so scr_addr tracks SP once the op completes.
   always_comb begin
      sp_next = sp;
      if (sp_load)     sp_next = addr_q;
      else if (sp_dec) sp_next = sp_minus1;
      else if (sp_inc) sp_next = sp + ADDR_W'(1);
   end

   assign bus.op_ready  = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign sp_out        = sp;
   // Reset kills a pending write in the cycle it is asserted.
   assign scr_wr        = wr_q && !rst;

   // Operation FSM with registered RAM drive and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= OP_ST;
         addr_q      <= '0;
         err_q       <= 1'b0;
         wr_q        <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         scr_addr    <= '0;
         scr_din     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.op_valid) begin
                  op_q    <= op_in;
                  addr_q  <= bus.op_addr;
                  err_q   <= err_in;
                  ready_q <= 1'b0;
                  state   <= EXEC;
                  case (op_in)
                     OP_ST: begin
                        scr_addr <= bus.op_addr;
                        scr_din  <= bus.op_data;
                        wr_q     <= 1'b1;
                     end
                     OP_LD: scr_addr <= bus.op_addr;
                     OP_PUSH, OP_CALL: begin
                        scr_addr <= sp_minus1;
                        scr_din  <= bus.op_data;
                        wr_q     <= !full;
                     end
                     default: scr_addr <= sp;
                  endcase
               end
            end
            EXEC: begin
               wr_q        <= 1'b0;
               scr_addr    <= sp_next;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= err_q;
               if (err_q)              rsp_data_q <= '0;
               else if (op_q == OP_RSP) rsp_data_q <= DATA_W'(sp);
               else                    rsp_data_q <= scr_dout;
               state       <= RESP;
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               ready_q     <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Scoreboard bench for scr_stack_ctrl with a behavioural stack/RAM reference model.
module tb_scr_stack_ctrl;
   import scr_pkg::*;

   localparam int MAXD = 64;

   typedef struct {
      int         cyc;
      logic       err;
      logic       chk_data;
      logic [9:0] data;
      int         sp;
   } rsp_t;

   typedef struct {
      int         addr;
      logic [9:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sp_out;
   logic [7:0] scr_addr;
   logic       scr_wr;
   logic [9:0] scr_din;
   logic [9:0] scr_dout;
   logic [9:0] ram [256];

   scr_stack_ctrl_if bus ();

   scr_stack_ctrl #(.MAX_DEPTH(MAXD)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .sp_out   (sp_out),
      .scr_addr (scr_addr),
      .scr_wr   (scr_wr),
      .scr_din  (scr_din),
      .scr_dout (scr_dout)
   );

   always #5 clk = ~clk;

   // Scratch RAM: async read, synchronous write.
   assign scr_dout = ram[scr_addr];
   always @(posedge clk) if (scr_wr) ram[scr_addr] <= scr_din;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int npass = 0;
   int ntot  = 0;

   rsp_t rq[$];
   wr_t  wq[$];

   // Reference model state
   logic [9:0] ref_mem [256];
   int ref_sp    = 0;
   int ref_depth = 0;

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Apply one accepted op to the model and queue the expected effects.
   task automatic model_apply(input logic [2:0] code, input int a, input logic [9:0] d, input int acc_cyc);
      rsp_t r;
      r.cyc = acc_cyc + 1;
      r.err = 1'b0;
      r.chk_data = 1'b0;
      r.data = '0;
      case (code)
         3'd0: begin ref_mem[a] = d; wq.push_back('{a, d}); end
         3'd1: begin r.chk_data = 1'b1; r.data = ref_mem[a]; end
         3'd2, 3'd4: begin
            if (ref_depth == MAXD) r.err = 1'b1;
            else begin
               ref_sp = (ref_sp + 255) % 256;
               ref_mem[ref_sp] = d;
               wq.push_back('{ref_sp, d});
               ref_depth++;
            end
         end
         3'd3, 3'd5: begin
            r.chk_data = 1'b1;
            if (ref_depth == 0) begin r.err = 1'b1; r.data = '0; end
            else begin
               r.data = ref_mem[ref_sp];
               ref_sp = (ref_sp + 1) % 256;
               ref_depth--;
            end
         end
         3'd6: begin ref_sp = a; ref_depth = 0; end
         default: begin r.chk_data = 1'b1; r.data = 10'(ref_sp); end
      endcase
      r.sp = ref_sp;
      rq.push_back(r);
   endtask

   task automatic issue(input logic [2:0] code, input int a, input logic [9:0] d);
      int n = 0;
      @(negedge clk);
      while (!bus.op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.op_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_addr  = 8'(a);
      bus.op_data  = d;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      model_apply(code, a, d, cyc);
   endtask

   task automatic drain();
      int n = 0;
      while (rq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0) chk("drain_timeout", rq.size(), 0);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      rq.delete();
      wq.delete();
      ref_sp = 0;
      ref_depth = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: compare responses and RAM writes against queued expectations.
   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            rsp_t r;
            r = rq.pop_front();
            chk("rsp_latency", cyc, r.cyc);
            chk("rsp_err", int'(bus.rsp_err), int'(r.err));
            if (r.chk_data) chk("rsp_data", int'(bus.rsp_data), int'(r.data));
            chk("rsp_sp", int'(sp_out), r.sp);
         end
      end
      if (scr_wr) begin
         if (wq.size() == 0) chk("wr_unexpected", int'(scr_addr), -1);
         else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", int'(scr_addr), w.addr);
            chk("wr_data", int'(scr_din), int'(w.data));
         end
      end
   end

   initial begin
      int acc;
      logic rdy;
      for (int i = 0; i < 256; i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      bus.op_valid = 1'b0;
      bus.op_code  = '0;
      bus.op_addr  = '0;
      bus.op_data  = '0;

      apply_reset();
      @(negedge clk);
      chk("rst_op_ready", int'(bus.op_ready), 1);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_data", int'(bus.rsp_data), 0);
      chk("rst_rsp_err", int'(bus.rsp_err), 0);
      chk("rst_scr_wr", int'(scr_wr), 0);
      chk("rst_scr_addr", int'(scr_addr), 0);
      chk("rst_scr_din", int'(scr_din), 0);
      chk("rst_sp", int'(sp_out), 0);

      // Direct store / load
      issue(3'(OP_ST), 'h10, 10'h2AB);
      issue(3'(OP_LD), 'h10, 10'h000);
      drain();

      // Push / pop ordering and wrap below 0
      issue(3'(OP_PUSH), 0, 10'h111);
      issue(3'(OP_PUSH), 0, 10'h222);
      issue(3'(OP_POP), 0, 10'h0);
      issue(3'(OP_POP), 0, 10'h0);
      drain();

      // Call / return around a written SP
      issue(3'(OP_WSP), 'h80, 10'h0);
      issue(3'(OP_CALL), 0, 10'h3FF);
      issue(3'(OP_RET), 0, 10'h0);
      issue(3'(OP_RSP), 0, 10'h0);
      drain();
      chk("sp_after_ret", int'(sp_out), 'h80);

      // Underflow, then fill to overflow
      apply_reset();
      issue(3'(OP_POP), 0, 10'h0);
      for (int i = 0; i < MAXD + 1; i++) issue(3'(OP_PUSH), 0, 10'($urandom));
      drain();
      chk("sp_at_full", int'(sp_out), 'hC0);

      // op_valid held high: one accept per three cycles
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'(OP_RSP);
      acc = 0;
      for (int c = 0; c < 9; c++) begin
         rdy = bus.op_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            acc++;
            model_apply(3'(OP_RSP), 0, 10'h0, cyc);
         end
         @(negedge clk);
      end
      bus.op_valid = 1'b0;
      chk("accept_count", acc, 3);
      drain();

      // Reset during EXEC of a PUSH aborts it
      issue(3'(OP_PUSH), 0, 10'h155);
      rst = 1'b1;
      rq.delete();
      wq.delete();
      ref_sp = 0;
      ref_depth = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_ready", int'(bus.op_ready), 1);
         chk("abort_sp", int'(sp_out), 0);
         chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
      end
      issue(3'(OP_POP), 0, 10'h0);
      drain();

      // Randomized mix
      for (int i = 0; i < 300; i++) begin
         issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 10'($urandom));
      end
      drain();
      chk("rsp_queue_empty", rq.size(), 0);
      chk("wr_queue_empty", wq.size(), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
